// File: rtl/count_sampler.sv
// rtl/count_sampler.sv - captures every change of a counter value into a small FIFO with a jump flag
// Head sample is held in its own register so Data_o/Jump_o only move on a pop or a push into empty.
module count_sampler #(
  parameter logic [31:0] InitVal = 32'd8,
  parameter logic [31:0] EndVal  = 32'd64,
  parameter int unsigned Depth   = 4
) (
  input  logic                     Clk_i,
  input  logic                     Reset_i,
  input  logic [31:0]              Data_i,
  output logic [31:0]              Data_o,
  output logic                     Jump_o,
  output logic                     Valid_o,
  input  logic                     Ready_i,
  output logic [$clog2(Depth):0]   Level_o,
  output logic                     Overflow_o,
  output logic                     Done_o
);

  localparam int unsigned AW = $clog2(Depth);
  localparam int unsigned LW = AW + 1;

  logic [32:0]   mem_q [Depth];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW-1:0] rd_next;
  logic [LW-1:0] lvl_q, lvl_d;
  logic [31:0]   prev_q;
  logic [31:0]   head_data_q, head_data_d;
  logic          head_jump_q, head_jump_d;
  logic          ovf_q, ovf_d;
  logic          done_q, done_d;
  logic          empty, full, push, pop, jump, wr_en;

  always_comb begin
    empty       = (lvl_q == '0);
    full        = (lvl_q == LW'(Depth));
    push        = (Data_i != prev_q);
    jump        = (Data_i != (prev_q + 32'd1));
    pop         = !empty && Ready_i;
    // A full FIFO still accepts a sample when the head leaves in the same cycle.
    wr_en       = push && (!full || pop);
    rd_next     = rd_q + AW'(1);

    wr_d        = wr_q;
    rd_d        = rd_q;
    lvl_d       = lvl_q;
    head_data_d = head_data_q;
    head_jump_d = head_jump_q;
    ovf_d       = ovf_q || (push && full && !pop);
    done_d      = done_q || (Data_i == EndVal);

    if (pop) begin
      rd_d = rd_next;
    end
    if (wr_en) begin
      wr_d = wr_q + AW'(1);
    end

    case ({wr_en, pop})
      2'b10:   lvl_d = lvl_q + LW'(1);
      2'b01:   lvl_d = lvl_q - LW'(1);
      default: lvl_d = lvl_q;
    endcase

    // The new sample becomes the head only if nothing older remains after this cycle.
    if (wr_en && (empty || (pop && lvl_q == LW'(1)))) begin
      head_data_d = Data_i;
      head_jump_d = jump;
    end else if (pop && lvl_q > LW'(1)) begin
      head_data_d = mem_q[rd_next][32:1];
      head_jump_d = mem_q[rd_next][0];
    end
  end

  always_ff @(posedge Clk_i) begin
    if (Reset_i) begin
      wr_q        <= '0;
      rd_q        <= '0;
      lvl_q       <= '0;
      prev_q      <= InitVal;
      head_data_q <= '0;
      head_jump_q <= 1'b0;
      ovf_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      lvl_q       <= lvl_d;
      prev_q      <= Data_i;
      head_data_q <= head_data_d;
      head_jump_q <= head_jump_d;
      ovf_q       <= ovf_d;
      done_q      <= done_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge Clk_i) begin
    if (!Reset_i && wr_en) begin
      mem_q[wr_q] <= {Data_i, jump};
    end
  end

  assign Data_o     = head_data_q;
  assign Jump_o     = head_jump_q;
  assign Valid_o    = !empty;
  assign Level_o    = lvl_q;
  assign Overflow_o = ovf_q;
  assign Done_o     = done_q;

endmodule

// File: tb/tb_count_sampler.sv
// tb/tb_count_sampler.sv - directed and randomized checks of count_sampler against a queue model
module tb_count_sampler;

  logic        clk;
  logic        Reset_i;
  logic [31:0] Data_i;
  logic [31:0] Data_o;
  logic        Jump_o;
  logic        Valid_o;
  logic        Ready_i;
  logic [2:0]  Level_o;
  logic        Overflow_o;
  logic        Done_o;

  int n_chk  = 0;
  int n_pass = 0;

  logic [32:0] mq[$];
  logic [31:0] m_prev;
  logic        m_ovf, m_done;

  count_sampler dut (
    .Clk_i      (clk),
    .Reset_i    (Reset_i),
    .Data_i     (Data_i),
    .Data_o     (Data_o),
    .Jump_o     (Jump_o),
    .Valid_o    (Valid_o),
    .Ready_i    (Ready_i),
    .Level_o    (Level_o),
    .Overflow_o (Overflow_o),
    .Done_o     (Done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle, advance the model by the same edge, then settle 1ns past the edge.
  task automatic cycle(input logic [31:0] d, input logic r, input logic rst);
    logic jmp;
    Data_i  = d;
    Ready_i = r;
    Reset_i = rst;
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_prev = 32'd8;
      m_ovf  = 1'b0;
      m_done = 1'b0;
    end else begin
      if (r && mq.size() > 0) void'(mq.pop_front());
      if (d != m_prev) begin
        jmp = (d != m_prev + 32'd1);
        if (mq.size() < 4) mq.push_back({d, jmp});
        else m_ovf = 1'b1;
      end
      if (d == 32'd64) m_done = 1'b1;
      m_prev = d;
    end
    #1;
  endtask

  task automatic test_reset();
    cycle(32'd8, 1'b0, 1'b1);
    cycle(32'd8, 1'b0, 1'b1);
    n_chk++; if (Valid_o !== 1'b0) $display("FAIL rst_valid got %0b exp 0", Valid_o); else n_pass++;
    n_chk++; if (Level_o !== 3'd0) $display("FAIL rst_level got %0d exp 0", Level_o); else n_pass++;
    n_chk++; if (Done_o !== 1'b0) $display("FAIL rst_done got %0b exp 0", Done_o); else n_pass++;
    n_chk++; if (Overflow_o !== 1'b0) $display("FAIL rst_ovf got %0b exp 0", Overflow_o); else n_pass++;
    n_chk++; if (Data_o !== 32'd0 || Jump_o !== 1'b0) $display("FAIL rst_head got %0d/%0b exp 0/0", Data_o, Jump_o); else n_pass++;
    cycle(32'd8, 1'b1, 1'b0);
    n_chk++; if (Valid_o !== 1'b0) $display("FAIL rst_stable got %0b exp 0", Valid_o); else n_pass++;
  endtask

  task automatic test_count_run();
    cycle(32'd9, 1'b1, 1'b0);
    n_chk++; if (Valid_o !== 1'b1 || Data_o !== 32'd9 || Jump_o !== 1'b0) $display("FAIL run_9 got %0b/%0d/%0b exp 1/9/0", Valid_o, Data_o, Jump_o); else n_pass++;
    cycle(32'd10, 1'b1, 1'b0);
    n_chk++; if (Valid_o !== 1'b1 || Data_o !== 32'd10 || Jump_o !== 1'b0) $display("FAIL run_10 got %0b/%0d/%0b exp 1/10/0", Valid_o, Data_o, Jump_o); else n_pass++;
    n_chk++; if (Level_o !== 3'd1) $display("FAIL run_level got %0d exp 1", Level_o); else n_pass++;
    cycle(32'd10, 1'b1, 1'b0);
    n_chk++; if (Valid_o !== 1'b0 || Level_o !== 3'd0) $display("FAIL run_drain got %0b/%0d exp 0/0", Valid_o, Level_o); else n_pass++;
  endtask

  task automatic test_jump();
    cycle(32'd8, 1'b0, 1'b1);
    cycle(32'd12, 1'b0, 1'b0);
    n_chk++; if (Data_o !== 32'd12 || Jump_o !== 1'b1) $display("FAIL jump_head got %0d/%0b exp 12/1", Data_o, Jump_o); else n_pass++;
    cycle(32'd12, 1'b0, 1'b0);
    cycle(32'd12, 1'b0, 1'b0);
    n_chk++; if (Level_o !== 3'd1) $display("FAIL jump_hold got %0d exp 1", Level_o); else n_pass++;
    cycle(32'd12, 1'b1, 1'b0);
    n_chk++; if (Valid_o !== 1'b0) $display("FAIL jump_pop got %0b exp 0", Valid_o); else n_pass++;
  endtask

  task automatic test_wrap();
    cycle(32'd8, 1'b0, 1'b1);
    cycle(32'hFFFF_FFFF, 1'b0, 1'b0);
    cycle(32'd0, 1'b0, 1'b0);
    n_chk++; if (Level_o !== 3'd2 || Jump_o !== 1'b1) $display("FAIL wrap_first got %0d/%0b exp 2/1", Level_o, Jump_o); else n_pass++;
    cycle(32'd0, 1'b1, 1'b0);
    n_chk++; if (Data_o !== 32'd0 || Jump_o !== 1'b0) $display("FAIL wrap_add got %0h/%0b exp 0/0", Data_o, Jump_o); else n_pass++;
  endtask

  task automatic test_overflow();
    logic [31:0] exp_d;
    cycle(32'd8, 1'b0, 1'b1);
    for (int v = 9; v <= 13; v++) cycle(v, 1'b0, 1'b0);
    n_chk++; if (Level_o !== 3'd4) $display("FAIL ovf_level got %0d exp 4", Level_o); else n_pass++;
    n_chk++; if (Overflow_o !== 1'b1) $display("FAIL ovf_flag got %0b exp 1", Overflow_o); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      exp_d = 32'd9 + k;
      n_chk++; if (Valid_o !== 1'b1 || Data_o !== exp_d) $display("FAIL ovf_drain%0d got %0b/%0d exp 1/%0d", k, Valid_o, Data_o, exp_d); else n_pass++;
      cycle(32'd13, 1'b1, 1'b0);
    end
    n_chk++; if (Valid_o !== 1'b0 || Level_o !== 3'd0) $display("FAIL ovf_empty got %0b/%0d exp 0/0", Valid_o, Level_o); else n_pass++;
  endtask

  task automatic test_full_simultaneous();
    logic [31:0] exp_d;
    for (int v = 14; v <= 17; v++) cycle(v, 1'b0, 1'b0);
    n_chk++; if (Level_o !== 3'd4 || Data_o !== 32'd14) $display("FAIL full_fill got %0d/%0d exp 4/14", Level_o, Data_o); else n_pass++;
    cycle(32'd18, 1'b1, 1'b0);
    n_chk++; if (Level_o !== 3'd4) $display("FAIL full_both got %0d exp 4", Level_o); else n_pass++;
    n_chk++; if (Overflow_o !== 1'b1) $display("FAIL full_sticky got %0b exp 1", Overflow_o); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      exp_d = 32'd15 + k;
      n_chk++; if (Data_o !== exp_d || Jump_o !== 1'b0) $display("FAIL full_drain%0d got %0d/%0b exp %0d/0", k, Data_o, Jump_o, exp_d); else n_pass++;
      cycle(32'd18, 1'b1, 1'b0);
    end
  endtask

  task automatic test_done_reset();
    cycle(32'd8, 1'b0, 1'b1);
    for (int v = 9; v <= 63; v++) cycle(v, 1'b1, 1'b0);
    n_chk++; if (Done_o !== 1'b0) $display("FAIL done_early got %0b exp 0", Done_o); else n_pass++;
    cycle(32'd64, 1'b1, 1'b0);
    n_chk++; if (Done_o !== 1'b1) $display("FAIL done_set got %0b exp 1", Done_o); else n_pass++;
    for (int v = 65; v <= 70; v++) cycle(v, 1'b0, 1'b0);
    n_chk++; if (Done_o !== 1'b1 || Overflow_o !== 1'b1) $display("FAIL done_sticky got %0b/%0b exp 1/1", Done_o, Overflow_o); else n_pass++;
    cycle(32'd70, 1'b1, 1'b1);
    n_chk++; if (Level_o !== 3'd0 || Valid_o !== 1'b0) $display("FAIL done_rst got %0d/%0b exp 0/0", Level_o, Valid_o); else n_pass++;
    n_chk++; if (Done_o !== 1'b0 || Overflow_o !== 1'b0) $display("FAIL done_rstflags got %0b/%0b exp 0/0", Done_o, Overflow_o); else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] d;
    logic        r, rst;
    int          sel, thr;
    cycle(32'd8, 1'b0, 1'b1);
    for (int i = 0; i < 2000; i++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1, 2, 3: d = m_prev;
        4, 5, 6:    d = m_prev + 32'd1;
        7:          d = $urandom;
        8:          d = 32'd64;
        default:    d = m_prev + $urandom_range(2, 5);
      endcase
      thr = ((i / 100) % 2 == 0) ? 25 : 85;
      r   = ($urandom_range(0, 99) < thr);
      rst = ($urandom_range(0, 299) == 0);
      cycle(d, r, rst);
      n_chk++; if (Valid_o !== (mq.size() > 0)) $display("FAIL rnd_valid@%0d got %0b exp %0b", i, Valid_o, mq.size() > 0); else n_pass++;
      n_chk++; if (Level_o !== 3'(mq.size())) $display("FAIL rnd_level@%0d got %0d exp %0d", i, Level_o, mq.size()); else n_pass++;
      n_chk++; if (Overflow_o !== m_ovf || Done_o !== m_done) $display("FAIL rnd_flags@%0d got %0b/%0b exp %0b/%0b", i, Overflow_o, Done_o, m_ovf, m_done); else n_pass++;
      if (mq.size() > 0) begin
        n_chk++; if ({Data_o, Jump_o} !== mq[0]) $display("FAIL rnd_head@%0d got %0h/%0b exp %0h/%0b", i, Data_o, Jump_o, mq[0][32:1], mq[0][0]); else n_pass++;
      end
    end
  endtask

  initial begin
    Reset_i = 1'b1;
    Data_i  = 32'd8;
    Ready_i = 1'b0;
    m_prev  = 32'd8;
    m_ovf   = 1'b0;
    m_done  = 1'b0;
    test_reset();
    test_count_run();
    test_jump();
    test_wrap();
    test_overflow();
    test_full_simultaneous();
    test_done_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
